// File: rtl/column_stream_writer.sv
// Column record feeder for the column decoder: sanitises wall geometry, buffers
// records in a small FIFO and emits each column as a hi/lo pair of 16-bit writes.
module column_stream_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_COLS   = 640,
  parameter int WRITE_GAP  = 0,
  parameter int FRAME_GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] in_coldata,
  output logic        chipselect,
  output logic        write,
  output logic [15:0] writedata,
  output logic [9:0]  col_count,
  output logic        frame_done,
  output logic        busy
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GAP_MAX = (WRITE_GAP > FRAME_GAP) ? WRITE_GAP : FRAME_GAP;
  localparam int CW      = $clog2(GAP_MAX + 1);
  localparam logic [CW-1:0] WG_LAST   = CW'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);
  localparam logic [CW-1:0] FG_LAST   = CW'(FRAME_GAP - 1);
  localparam logic [9:0]    COLS_LAST = 10'(NUM_COLS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_GAP_A,
    ST_WR_LO,
    ST_GAP_B,
    ST_FRAME_GAP
  } state_t;

  // Stored record layout matches the input: {top, dir, tex, height, offset}.
  function automatic logic [27:0] sanitise(input logic [27:0] rec);
    logic [8:0] top;
    logic [8:0] hgt;
    logic [9:0] sum;
    top = rec[27:19];
    if (top > 9'd479) top = 9'd479;
    hgt = rec[14:6];
    sum = {1'b0, top} + {1'b0, hgt};
    if (sum > 10'd480) hgt = 9'(10'd480 - {1'b0, top});
    return {top, rec[18:15], hgt, rec[5:0]};
  endfunction

  function automatic logic [15:0] hi_word(input logic [27:0] rec);
    return {3'b000, rec[27:15]};
  endfunction

  function automatic logic [15:0] lo_word(input logic [27:0] rec);
    return {1'b0, rec[14:0]};
  endfunction

  logic [27:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic [27:0]   head;
  logic [27:0]   rec_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    col_q, col_d;
  logic          write_q, write_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          fd_q, fd_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= sanitise(in_coldata);
    if (pop)  rec_q <= head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // The record is popped on every entry into WR_HI, so a hi word is never
  // issued without its lo word following unless reset intervenes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_WR_HI;
          pop     = 1'b1;
        end
      end
      ST_WR_HI: begin
        if (WRITE_GAP > 0) begin
          state_d = ST_GAP_A;
          cnt_d   = '0;
        end else begin
          state_d = ST_WR_LO;
        end
      end
      ST_GAP_A: begin
        if (cnt_q == WG_LAST) state_d = ST_WR_LO;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      ST_WR_LO: begin
        if (col_q == COLS_LAST) begin
          state_d = ST_FRAME_GAP;
          cnt_d   = '0;
        end else if (WRITE_GAP > 0) begin
          state_d = ST_GAP_B;
          cnt_d   = '0;
        end else if (!fifo_empty) begin
          state_d = ST_WR_HI;
          pop     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP_B: begin
        if (cnt_q == WG_LAST) begin
          if (!fifo_empty) begin
            state_d = ST_WR_HI;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FRAME_GAP: begin
        if (cnt_q == FG_LAST) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    fd_d = (state_d == ST_FRAME_GAP) && (cnt_d == FG_LAST);
    if (fd_d)                        col_d = '0;
    else if (state_d == ST_WR_LO)    col_d = col_q + 10'd1;

    write_d = (state_d == ST_WR_HI) || (state_d == ST_WR_LO);
    if (state_d == ST_WR_HI)       wdata_d = hi_word(head);
    else if (state_d == ST_WR_LO)  wdata_d = lo_word(rec_q);
    else                           wdata_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      fd_q    <= fd_d;
    end
  end

  assign write      = write_q;
  assign chipselect = write_q;
  assign writedata  = wdata_q;
  assign col_count  = col_q;
  assign frame_done = fd_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: doc/column_stream_writer.md
# column_stream_writer

Upstream feeder for the column decoder. Accepts one 28-bit ray-cast column record per handshake from the column producer (software bridge or hardware ray engine), sanitises the wall geometry, buffers records in a small FIFO, and drives the decoder's 16-bit write port as two consecutive writes per column. After every 640th column it holds a mandatory idle gap, so the decoder can detect frame completion and swap column buffers.

## Interface

Parameters:
- FIFO_DEPTH, 8, record FIFO entries (power of two, ≥2)
- NUM_COLS, 640, columns per frame
- WRITE_GAP, 0, idle cycles between the hi and lo writes of a column and between columns
- FRAME_GAP, 4, idle cycles after the last write of a frame (≥2)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a record
- in_ready  out  1  writer accepts a record this cycle
- in_coldata  in  28  {top[27:19], dir[18], tex[17:15], height[14:6], offset[5:0]}
- chipselect  out  1  decoder select, asserted with write
- write  out  1  one-cycle write strobe
- writedata  out  16  write payload
- col_count  out  10  columns fully written in the current frame
- frame_done  out  1  one-cycle pulse at the end of the frame gap
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation

- Accept: a record is accepted when in_valid && in_ready. in_ready = !fifo_full. There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- Sanitise before the FIFO write:
  - top' = min(top, 479).
  - sum = top' + height, computed at 10 bits.
  - height' = (sum > 480) ? 480 − top' : height.
  - dir, tex and offset pass through unchanged.
- Encoding:
  - hi word = {3'b0, top', dir, tex}.
  - lo word = {1'b0, height', offset}.
  - The hi word is always written first.
- FSM states: IDLE, WR_HI, GAP_A, WR_LO, GAP_B, FRAME_GAP.
  - IDLE → WR_HI when the FIFO is non-empty. The record is popped and latched on entry to WR_HI.
  - WR_HI → GAP_A when WRITE_GAP > 0, else → WR_LO. GAP_A lasts WRITE_GAP cycles, then → WR_LO.
  - WR_LO: col_count increments.
    - If col_count reaches NUM_COLS → FRAME_GAP.
    - Else → GAP_B when WRITE_GAP > 0, else directly to WR_HI if the FIFO is non-empty, or IDLE if it is empty.
  - GAP_B lasts WRITE_GAP cycles, then → WR_HI if the FIFO is non-empty, else IDLE.
  - FRAME_GAP lasts FRAME_GAP cycles with no writes, even if the FIFO is non-empty. On its last cycle it pulses frame_done, clears col_count to 0, and returns to IDLE.
- write and chipselect are asserted only in WR_HI and WR_LO. writedata holds the word during the strobe and is 0 otherwise.
- The writer never emits an unpaired hi word except when interrupted by reset.

## Timing

- Reset values: in_ready 1, chipselect 0, write 0, writedata 0, col_count 0, frame_done 0, busy 0. The FIFO is empty and the FSM is in IDLE.
- Outputs are registered except in_ready and busy. Reset clears all state immediately.
- Latency, with WRITE_GAP = 0 and the writer idle:
  - record accepted at edge N;
  - hi write strobe in cycle N+1;
  - lo write strobe in cycle N+2.
- Sustained throughput is one column per 2 + 2·WRITE_GAP cycles. A full frame takes NUM_COLS·(2 + 2·WRITE_GAP) + FRAME_GAP cycles when the FIFO never runs dry.
- Reset mid-column (between hi and lo) discards the partial column. The decoder shares the same reset, so its write-stage toggle realigns.
- col_count rolls to 0 only through FRAME_GAP. It never wraps past NUM_COLS.

## Test plan

- Single record: top=100, dir=1, tex=5, height=200, offset=17.
  - Required: writedata 0x064D (hi) in cycle N+1, then 0x3211 (lo) in cycle N+2.
  - Required: col_count=1; busy drops the cycle after the lo write.
- Clamp case A: top=500, height=100, dir=0, tex=0, offset=0.
  - Required: hi=0x1DF0, lo=0x0040.
- Clamp case B: top=400, height=200.
  - Required: lo height field = 80 (lo=0x1400 with offset 0).
- Backpressure, FIFO_DEPTH=8: 20 records offered back-to-back with in_valid held high.
  - Required: in_ready deasserts while the FIFO is full; all 20 columns are written in order; no loss or duplication; 40 write strobes.
- Frame boundary: 645 records streamed.
  - Required: exactly 1280 strobes, then 4 cycles with write=0, then frame_done pulses once and col_count=0.
  - Required: writes for records 641–645 follow, with the hi word first.
- Gap and reset, WRITE_GAP=2: check a 2-cycle gap between every strobe.
  - Then assert reset between a hi and lo write. Required: write, chipselect and writedata go 0 immediately; the FIFO is empty.
  - After reset the first strobe is the hi word of a newly accepted record.
